// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulation stage: default widths,
// block length, saturation limits and the control state encoding.
package product_accum_pkg;

    localparam int PROD_W = 10;
    localparam int ACC_W  = 12;
    localparam int COUNT  = 8;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in, block result out. The master side is the upstream
// multiplier/consumer pair, the slave side is the accumulator itself.
interface product_accumulator_if;
    import product_accum_pkg::*;

    logic                     start;
    logic signed [PROD_W-1:0] prod;
    logic                     prod_valid;
    logic                     prod_ready;
    logic signed [ACC_W-1:0]  sum;
    logic                     sum_valid;
    logic                     sum_ready;
    logic                     overflow;
    logic                     busy;

    modport master (
        output start, prod, prod_valid, sum_ready,
        input  prod_ready, sum, sum_valid, overflow, busy
    );

    modport slave (
        input  start, prod, prod_valid, sum_ready,
        output prod_ready, sum, sum_valid, overflow, busy
    );

endinterface

// File: rtl/product_accumulator_sat_add.sv
// Signed saturating adder built as a ripple of full-adder bits. Both operands
// are sign-extended one bit beyond the result width so the true sum is never
// lost; the two top bits of that extended sum tell us which way it overflowed.
module sat_add #(
    parameter int A_W = 12,
    parameter int B_W = 10,
    parameter int S_W = 12
) (
    input  logic signed [A_W-1:0] a_i,
    input  logic signed [B_W-1:0] b_i,
    output logic signed [S_W-1:0] sum_o,
    output logic                  ovf_o
);

    localparam int X_W = S_W + 1;
    localparam logic [S_W-1:0] S_MAX = {1'b0, {(S_W-1){1'b1}}};
    localparam logic [S_W-1:0] S_MIN = {1'b1, {(S_W-1){1'b0}}};

    logic [X_W-1:0] a_x_s;
    logic [X_W-1:0] b_x_s;
    logic [X_W-1:0] raw_s;
    logic [X_W-1:0] carry_s;

    assign a_x_s      = {{(X_W-A_W){a_i[A_W-1]}}, a_i};
    assign b_x_s      = {{(X_W-B_W){b_i[B_W-1]}}, b_i};
    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < X_W; i++) begin : g_sum
        assign raw_s[i] = a_x_s[i] ^ b_x_s[i] ^ carry_s[i];
    end

    for (genvar i = 0; i < X_W - 1; i++) begin : g_carry
        assign carry_s[i+1] = (a_x_s[i] & b_x_s[i]) | (carry_s[i] & (a_x_s[i] ^ b_x_s[i]));
    end

    // Clamp to the representable range when the extended sum leaves it.
    always_comb begin
        sum_o = raw_s[S_W-1:0];
        ovf_o = 1'b0;
        case ({raw_s[X_W-1], raw_s[X_W-2]})
            2'b01: begin
                sum_o = S_MAX;
                ovf_o = 1'b1;
            end
            2'b10: begin
                sum_o = S_MIN;
                ovf_o = 1'b1;
            end
            default: begin
                sum_o = raw_s[S_W-1:0];
                ovf_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a fixed-length block of signed products into a saturating
// accumulator and holds the block result until the consumer takes it.
// Handshake outputs are decoded from the state register only.
module product_accumulator
    import product_accum_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    product_accumulator_if.slave bus_if
);

    localparam int              CNT_W    = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic                    ovf_q;
    logic                    add_ovf_s;
    logic                    prod_hs_s;

    sat_add #(
        .A_W (ACC_W),
        .B_W (PROD_W),
        .S_W (ACC_W)
    ) u_sat_add (
        .a_i   (acc_q),
        .b_i   (bus_if.prod),
        .sum_o (acc_d),
        .ovf_o (add_ovf_s)
    );

    assign prod_hs_s         = bus_if.prod_valid && (state_q == ST_ACCUM);
    assign bus_if.prod_ready = (state_q == ST_ACCUM);
    assign bus_if.sum_valid  = (state_q == ST_HOLD);
    assign bus_if.busy       = (state_q != ST_IDLE);
    assign bus_if.sum        = acc_q;
    assign bus_if.overflow   = ovf_q;

    // Block control: clear on start, accumulate on handshake, hold for the consumer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            acc_q   <= {ACC_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.start) begin
                        state_q <= ST_ACCUM;
                        cnt_q   <= {CNT_W{1'b0}};
                        acc_q   <= {ACC_W{1'b0}};
                        ovf_q   <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (prod_hs_s) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_q | add_ovf_s;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // start arriving with sum_ready is deliberately dropped.
                    if (bus_if.sum_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator. A behavioural model (plain integer
// arithmetic with clamping) predicts every output each cycle; literal checks
// pin the model and the block-level timing.
module tb_product_accumulator;

    logic clk;
    logic reset_n;

    product_accumulator_if bus();

    product_accumulator dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus_if    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: phase 0 idle, 1 taking products, 2 result waiting
    int m_phase = 0;
    int m_acc   = 0;
    int m_taken = 0;
    int m_ovf   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_acc   = 0;
        m_taken = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step();
        int t;
        if (!reset_n) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (bus.start) begin
                m_phase = 1;
                m_acc   = 0;
                m_taken = 0;
                m_ovf   = 0;
            end
        end else if (m_phase == 1) begin
            if (bus.prod_valid) begin
                t = m_acc + int'(bus.prod);
                if (t > 2047) begin
                    t     = 2047;
                    m_ovf = 1;
                end else if (t < -2048) begin
                    t     = -2048;
                    m_ovf = 1;
                end
                m_acc   = t;
                m_taken = m_taken + 1;
                if (m_taken == 8) m_phase = 2;
            end
        end else begin
            if (bus.sum_ready) m_phase = 0;
        end
    endtask

    task automatic compare_outputs();
        chk("prod_ready", int'(bus.prod_ready), int'(m_phase == 1));
        chk("sum_valid",  int'(bus.sum_valid),  int'(m_phase == 2));
        chk("busy",       int'(bus.busy),       int'(m_phase != 0));
        chk("sum",        int'({20'd0, bus.sum}), m_acc & 32'hFFF);
        chk("overflow",   int'(bus.overflow),   m_ovf);
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_block(input int v[8], input bit gaps, input int hold_wait,
                             input int exp_sum, input int exp_ovf, input int exp_lat);
        int ticks;
        int w;
        int dur;
        bus.sum_ready = (hold_wait == 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ticks = 1;
        for (int i = 0; i < 8; i++) begin
            bus.prod       = 10'(v[i]);
            bus.prod_valid = 1'b1;
            tick();
            ticks++;
            if (gaps) begin
                bus.prod       = 10'h155;
                bus.prod_valid = 1'b0;
                tick();
                ticks++;
            end
        end
        bus.prod_valid = 1'b0;
        w = 0;
        while (!bus.sum_valid && w < 20) begin
            tick();
            ticks++;
            w++;
        end
        chk("sum_valid_seen", int'(bus.sum_valid), 1);
        if (exp_lat > 0) chk("latency_inclusive", ticks + 1, exp_lat);
        chk("sum_literal", int'({20'd0, bus.sum}), exp_sum & 32'hFFF);
        chk("ovf_literal", int'(bus.overflow), exp_ovf);
        chk("model_acc", m_acc, exp_sum);
        for (int i = 0; i < hold_wait; i++) begin
            tick();
            chk("hold_sum_stable", int'({20'd0, bus.sum}), exp_sum & 32'hFFF);
            chk("hold_valid", int'(bus.sum_valid), 1);
            chk("hold_prod_ready", int'(bus.prod_ready), 0);
        end
        bus.sum_ready = 1'b1;
        dur = 0;
        while (bus.sum_valid && dur < 20) begin
            tick();
            dur++;
        end
        if (hold_wait == 0) chk("sum_valid_cycles", dur, 1);
        bus.sum_ready = 1'b0;
        chk("busy_after_accept", int'(bus.busy), 0);
    endtask

    int v_basic[8] = '{-40, -33, 110, 0, 1, 2, 3, 4};
    int v_pos[8]   = '{300, 300, 300, 300, 300, 300, 300, 300};
    int v_neg[8]   = '{-512, -512, -512, -512, -512, -512, -512, -512};
    int v_ones[8]  = '{1, 1, 1, 1, 1, 1, 1, 1};
    int v_seq[8]   = '{1, 2, 3, 4, 5, 6, 7, 8};

    initial begin
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.prod       = 10'd0;
        bus.prod_valid = 1'b0;
        bus.sum_ready  = 1'b0;
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_sum", int'({20'd0, bus.sum}), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_sum_valid", int'(bus.sum_valid), 0);

        // basic block: 47, single-cycle valid, 10 cycles inclusive
        run_block(v_basic, 1'b0, 0, 47, 0, 10);
        // saturation both ways, then recovery from the clamped block
        run_block(v_pos, 1'b0, 0, 2047, 1, 10);
        run_block(v_neg, 1'b0, 0, -2048, 1, 10);
        run_block(v_ones, 1'b0, 0, 8, 0, 10);
        // backpressure: gapped stream, consumer stalls 5 cycles
        run_block(v_basic, 1'b1, 5, 47, 0, 0);

        // ignored controls
        bus.sum_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.prod       = 10'(v_seq[i]);
            bus.prod_valid = 1'b1;
            bus.start      = (i == 3);
            tick();
        end
        bus.start      = 1'b0;
        bus.prod_valid = 1'b0;
        tick();
        tick();
        chk("ign_sum", int'({20'd0, bus.sum}), 36);
        chk("ign_hold_busy", int'(bus.busy), 1);
        bus.start     = 1'b1;
        bus.sum_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.sum_ready = 1'b0;
        bus.prod       = 10'd5;
        bus.prod_valid = 1'b1;
        tick();
        bus.prod_valid = 1'b0;
        tick();
        chk("ign_idle_busy", int'(bus.busy), 0);
        chk("ign_idle_prod_ready", int'(bus.prod_ready), 0);
        chk("ign_acc_kept", int'({20'd0, bus.sum}), 36);

        // reset mid-block after the 3rd product
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.prod       = 10'(100 * (i + 1));
            bus.prod_valid = 1'b1;
            tick();
        end
        chk("pre_rst_sum", int'({20'd0, bus.sum}), 600);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_sum", int'({20'd0, bus.sum}), 0);
        chk("arst_prod_ready", int'(bus.prod_ready), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_sum_valid", int'(bus.sum_valid), 0);
        chk("arst_overflow", int'(bus.overflow), 0);
        model_reset();
        bus.prod_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run_block(v_seq, 1'b0, 0, 36, 0, 10);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
